// File: rtl/int_flag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_flag_ctrl
// Purpose  : IF (FF0F) interrupt flag register. Edge-detects peripheral
//            request levels into sticky flags, clears them on acknowledge or
//            CPU write, and reports pending / halt-wake status.
// Revision : 1.0  initial release
// ============================================================================
module int_flag_ctrl #(
  parameter logic [15:0] IF_ADDR  = 16'hFF0F,
  parameter logic [2:0]  PAD_BITS = 3'b111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  src_req,
  input  logic [4:0]  int_ack,
  input  logic [4:0]  ie_mask,
  input  logic [15:0] A,
  input  logic [7:0]  Di,
  output logic [7:0]  Do,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic        cs,
  output logic [4:0]  int_req,
  output logic        pending,
  output logic        wake
);

  logic [4:0] flags_q, flags_d;
  logic [4:0] req_prev_q, req_prev_d;
  logic       wr_prev_n_q, wr_prev_n_d;
  logic [7:0] reg_out_q, reg_out_d;

  logic [4:0] rise;
  logic       wr_ev;
  logic       rd_ev;

  // IF bits 7:5 do not exist; write data there is discarded.
  logic unused_di;
  assign unused_di = ^Di[7:5];

  // Next-state: a fresh rise beats an ack, an ack beats write data; a held
  // write strobe is applied only on its first low cycle.
  always_comb begin
    rise        = src_req & ~req_prev_q;
    wr_ev       = cs && !wr_n && wr_prev_n_q && (A == IF_ADDR);
    rd_ev       = cs && !rd_n && !wr_ev && (A == IF_ADDR);
    flags_d     = ((wr_ev ? Di[4:0] : flags_q) & ~int_ack) | rise;
    req_prev_d  = src_req;
    wr_prev_n_d = wr_n;
    reg_out_d   = reg_out_q;
    if (rd_ev) begin
      reg_out_d = {PAD_BITS, flags_q};
    end
  end

  // State registers with asynchronous clear; pending flags are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags_q     <= 5'h00;
      req_prev_q  <= 5'h00;
      wr_prev_n_q <= 1'b1;
      reg_out_q   <= 8'h00;
    end else begin
      flags_q     <= flags_d;
      req_prev_q  <= req_prev_d;
      wr_prev_n_q <= wr_prev_n_d;
      reg_out_q   <= reg_out_d;
    end
  end

  assign int_req = flags_q;
  assign pending = |flags_q;
  assign wake    = |(flags_q & ie_mask);
  assign Do      = cs ? reg_out_q : 8'hFF;

endmodule
`default_nettype wire

// File: doc/int_flag_ctrl.md
# int_flag_ctrl

Owns the IF (Interrupt Flag, FF0F) register for the Game Boy core and feeds the interrupt unit's `int_req` input. It edge-detects level request lines from the peripherals (V-Blank, LCDC, timer, serial, joypad) and latches each request as a sticky flag. Flags clear on the interrupt unit's `int_ack` pulse or on a CPU write to FF0F. It also reports a halt-wake condition against the current IE mask.

## Interface
- `IF_ADDR`, 16'hFF0F, bus address of the IF register
- `PAD_BITS`, 3'b111, value returned in read data bits [7:5]
- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `src_req`  in  5  level request lines; bit 0 V-Blank, 1 LCDC, 2 timer, 3 serial, 4 joypad
- `int_ack`  in  5  one-hot acknowledge from the interrupt unit; clears the matching flag
- `ie_mask`  in  5  current IE[4:0], used only for `wake`
- `A`  in  16  CPU address
- `Di`  in  8  CPU write data
- `Do`  out  8  read data; `cs ? reg_out : 8'hFF`
- `wr_n`  in  1  active-low write strobe
- `rd_n`  in  1  active-low read strobe
- `cs`  in  1  chip select for this block's address range
- `int_req`  out  5  IF[4:0] flags, registered
- `pending`  out  1  `|int_req`
- `wake`  out  1  `|(int_req & ie_mask)`, for HALT exit

## Operation
- Registers: `flags[4:0]`, `req_prev[4:0]`, `wr_prev_n`, `reg_out[7:0]`.
- Rise detect: `rise = src_req & ~req_prev`. `req_prev <= src_req` every cycle.
- Write event: `wr_ev = cs && !wr_n && wr_prev_n && A == IF_ADDR`. `wr_prev_n <= wr_n` every cycle. A write strobe held low for several cycles is applied exactly once.
- Flag update, per bit, every cycle: `flags <= ((wr_ev ? Di[4:0] : flags) & ~int_ack) | rise`.
  - A new rising edge always wins over an ack or a write in the same cycle, so no request is lost.
  - An ack wins over write data in the same cycle.
  - An ack for a bit that is already 0 has no effect.
  - A rise on a bit that is already 1 coalesces into that bit; there is no count.
- Read: when `cs && !rd_n && !wr_ev && A == IF_ADDR`, `reg_out <= {PAD_BITS, flags}`. The read samples the flags before this cycle's update. For other addresses `reg_out` holds its value.
- `Di[7:5]` is ignored.
- `int_req`, `pending` and `wake` are driven combinationally from `flags`, `ie_mask` and `int_req`; they do not depend on the bus.

## Timing
- Reset values:
  - `flags = 0`, `req_prev = 0`, `wr_prev_n = 1`, `reg_out = 8'h00`.
  - Outputs: `int_req = 0`, `pending = 0`, `wake = 0`. `Do = 8'h00` if `cs` is high, else 8'hFF.
- Reset asserted mid-operation clears everything asynchronously; pending flags are lost.
- After reset release, any `src_req` bit already high is seen as a rise on the first clock edge (because `req_prev` resets to 0).
- Request latency: `src_req` sampled high at edge N with `req_prev` 0 gives `int_req` high after edge N. That is 1 cycle.
- Ack latency: `int_ack` high at edge N gives the flag 0 after edge N, unless the same bit rises at edge N.
- Write latency: on the first cycle of the strobe, the new flags are visible after that edge.
- Read: `Do` is valid the cycle after `rd_n` and `cs` are sampled low, and holds until the next qualifying read.
- A `src_req` level held high produces exactly one set. After the bit is acked or cleared, it re-sets only after `src_req` goes low and then high again.

## Test plan
- Reset:
  - Stimulus: assert `reset` asynchronously mid-cycle with `flags = 5'h1F`.
  - Required: `int_req = 0` immediately.
  - Stimulus: release with `src_req = 5'h04`.
  - Required: `int_req = 5'h04` after the first edge.
- Edge and coalesce:
  - Stimulus: pulse `src_req[0]` for 1 cycle, then hold `src_req[2]` high for 10 cycles.
  - Required: `int_req = 5'h05` and stays there; `pending = 1`.
  - Stimulus: pulse `src_req[0]` again.
  - Required: `int_req` is unchanged.
- Ack vs rise collision:
  - Stimulus: `int_ack = 5'h02` and a `src_req[1]` rise in the same cycle.
  - Required: bit 1 stays 1.
  - Stimulus: `int_ack = 5'h02` alone on the next cycle.
  - Required: bit 1 is 0.
- CPU write:
  - Stimulus: hold `wr_n` low for 3 cycles at FF0F with `Di = 8'hFF`, while a `src_req[3]` edge occurs in the 2nd cycle.
  - Required: `int_req = 5'h1F`.
  - Stimulus: write 8'h00.
  - Required: `int_req = 5'h00`.
  - Stimulus: write 8'h00 in the same cycle as a `src_req[4]` rise.
  - Required: `int_req = 5'h10`.
- Read-back:
  - Stimulus: `flags = 5'h09`; read FF0F.
  - Required: `Do = 8'hE9` one cycle later.
  - Stimulus: read FFFF.
  - Required: `Do` holds 8'hE9.
  - Stimulus: `cs = 0`.
  - Required: `Do = 8'hFF`.
- Wake:
  - Stimulus: `flags = 5'h04`, `ie_mask = 5'h03`.
  - Required: `wake = 0`.
  - Stimulus: set `ie_mask = 5'h07`.
  - Required: `wake = 1` in the same cycle.
